// File: rtl/matmul_sequencer.sv
// matmul_sequencer: sequences C = A x B over NxN signed elements through a shared multiplier.
// Build option MATMUL_SAT_EN saturates out-of-range results instead of wrapping them.
module matmul_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 16,
  parameter int MAX_N = 5,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               size,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W-1:0]        a_addr,
  output logic [ADDR_W-1:0]        b_addr,
  input  logic signed [DATA_W-1:0] a_data,
  input  logic signed [DATA_W-1:0] b_data,
  output logic signed [DATA_W-1:0] mul_a,
  output logic signed [DATA_W-1:0] mul_b,
  input  logic signed [DATA_W-1:0] mul_prod,
  input  logic                     mul_ovf,
  output logic                     c_wr_en,
  output logic [ADDR_W-1:0]        c_addr,
  output logic signed [DATA_W-1:0] c_data,
  output logic                     ovf
);
  typedef enum logic [2:0] {IDLE, FETCH, MAC, WRITE, DONE} state_t;
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(2**(DATA_W-1)-1);
  localparam logic signed [ACC_W-1:0] LO = -HI - ACC_W'(1);
  state_t state, nxt;
  logic [2:0] n, i, j, k;
  logic signed [ACC_W-1:0] acc;
  logic rej, bad_size, last_k, last_j, last_ij, acc_hi, acc_lo;
  logic [ADDR_W-1:0] nn;
  logic signed [DATA_W-1:0] res;
  assign bad_size = int'(size) < 2 || int'(size) > MAX_N;
  assign last_k = k == n - 3'd1;
  assign last_j = j == n - 3'd1;
  assign last_ij = last_j && i == n - 3'd1;
  assign acc_hi = acc > HI;
  assign acc_lo = acc < LO;
  assign nn = ADDR_W'(n);
`ifdef MATMUL_SAT_EN
  assign res = acc_hi ? HI[DATA_W-1:0] : acc_lo ? LO[DATA_W-1:0] : acc[DATA_W-1:0];
`else
  assign res = acc[DATA_W-1:0];
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = !start ? IDLE : bad_size ? DONE : FETCH;
      FETCH: nxt = MAC;
      MAC:   nxt = last_k ? WRITE : FETCH;
      WRITE: nxt = last_ij ? DONE : FETCH;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      n <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      ovf <= 1'b0;
      rej <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ovf <= 1'b0;
          rej <= bad_size;
          if (!bad_size) begin
            n <= size;
            i <= '0;
            j <= '0;
            k <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-DATA_W){mul_prod[DATA_W-1]}}, mul_prod};
          ovf <= ovf | mul_ovf;
          if (!last_k) k <= k + 3'd1;
        end
        WRITE: begin
          ovf <= ovf | acc_hi | acc_lo;
          acc <= '0;
          k <= '0;
          j <= last_j ? 3'd0 : j + 3'd1;
          if (last_j) i <= i + 3'd1;
        end
        default: ;
      endcase
    end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    err = state == DONE && rej;
    a_addr = state == FETCH ? ADDR_W'(i) * nn + ADDR_W'(k) : '0;
    b_addr = state == FETCH ? ADDR_W'(k) * nn + ADDR_W'(j) : '0;
    mul_a = state == MAC ? a_data : '0;
    mul_b = state == MAC ? b_data : '0;
    c_wr_en = state == WRITE;
    c_addr = state == WRITE ? ADDR_W'(i) * nn + ADDR_W'(j) : '0;
    c_data = state == WRITE ? res : '0;
  end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: randomized self-checking bench against a plain-arithmetic matrix product model.
module tb_matmul_sequencer;
  logic clk = 0, rst = 1, start = 0;
  logic [2:0] size = 0;
  logic busy, done, err, c_wr_en, ovf, mul_ovf;
  logic [4:0] a_addr, b_addr, c_addr;
  logic signed [7:0] a_data, b_data, mul_a, mul_b, mul_prod, c_data;
  logic signed [15:0] full;
  logic signed [7:0] ma[32], mb[32];
  int pas = 0, tot = 0, cyc_g = 0, force_cyc = -1;
  int ec[25];
  bit eovf, spam = 0;
  int spam_until;
  int wa[$], wd[$];
  int done_cnt, err_cnt, act, busy_bad, ovf1;

  always #5 clk = ~clk;

  matmul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .busy(busy), .done(done), .err(err),
    .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod), .mul_ovf(mul_ovf),
    .c_wr_en(c_wr_en), .c_addr(c_addr), .c_data(c_data), .ovf(ovf)
  );

  // operand register files with one-cycle read latency, and the shared multiplier
  always @(posedge clk) begin
    a_data <= ma[a_addr];
    b_data <= mb[b_addr];
  end
  assign full = mul_a * mul_b;
  assign mul_prod = full[7:0];
  assign mul_ovf = (full > 127 || full < -128) || (cyc_g == force_cyc);

  always @(negedge clk) begin
    if (c_wr_en) begin
      wa.push_back(int'(c_addr));
      wd.push_back(int'(c_data));
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (a_addr != 0 || b_addr != 0 || mul_a != 0 || mul_b != 0) act++;
  end

  function automatic int lat(int n);
    return n * n * (2 * n + 1) + 1;
  endfunction

  function automatic void model(int n, bit forced);
    logic signed [7:0] t;
    eovf = forced;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        int s = 0;
        for (int k = 0; k < n; k++) begin
          int p = int'(ma[i*n+k]) * int'(mb[k*n+j]);
          if (p > 127 || p < -128) eovf = 1;
          t = p[7:0];
          s += int'(t);
        end
        if (s > 127 || s < -128) eovf = 1;
`ifdef MATMUL_SAT_EN
        ec[i*n+j] = s > 127 ? 127 : s < -128 ? -128 : s;
`else
        t = s[7:0];
        ec[i*n+j] = int'(t);
`endif
      end
  endfunction

  function automatic int wr_errs(int n);
    int e = 0;
    if (wa.size() != n * n) return 1000 + wa.size();
    for (int x = 0; x < n * n; x++) if (wa[x] != x || wd[x] != ec[x]) e++;
    return e;
  endfunction

  function automatic void fill(int n, bit wide);
    for (int x = 0; x < n * n; x++) begin
      ma[x] = wide ? 8'($urandom) : 8'($urandom_range(14) - 7);
      mb[x] = wide ? 8'($urandom) : 8'($urandom_range(14) - 7);
    end
  endfunction

  task automatic launch(input logic [2:0] sz, input bit hold);
    wa.delete();
    wd.delete();
    done_cnt = 0;
    err_cnt = 0;
    act = 0;
    busy_bad = 0;
    @(negedge clk);
    start = 1;
    size = sz;
    @(negedge clk);
    start = hold;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int c = 1; c <= 400; c++) begin
      cyc_g = c;
      if (c == 1) ovf1 = int'(ovf);
      if (spam) begin
        start = (c % 3 == 0) && (c < spam_until);
        size = 3'($urandom);
      end
      if (!busy) busy_bad++;
      if (done) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
    cyc_g = 0;
    if (spam) start = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    tot++; if ({busy, done, err, c_wr_en, ovf, a_addr, b_addr, c_addr, mul_a, mul_b, c_data} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {busy, done, err, c_wr_en, ovf, a_addr, b_addr, c_addr, mul_a, mul_b, c_data});
    else pas++;
    rst = 0;
  endtask

  task automatic test_example;
    int dc;
    for (int x = 0; x < 4; x++) begin
      ma[x] = 8'(x + 1);
      mb[x] = 8'(x + 5);
    end
    model(2, 0);
    launch(2, 0);
    wait_done(dc);
    tot++; if (dc !== 21) $display("FAIL ex_latency: got %0d want 21", dc); else pas++;
    tot++; if (!(wd.size() == 4 && wd[0] == 19 && wd[1] == 22 && wd[2] == 43 && wd[3] == 50 && wr_errs(2) == 0))
      $display("FAIL ex_writes: got %0d writes, %0d wrong, want 4 writes 19,22,43,50", wd.size(), wr_errs(2));
    else pas++;
    tot++; if (busy_bad !== 0) $display("FAIL ex_busy: got %0d idle cycles want 0", busy_bad); else pas++;
    @(negedge clk);
    tot++; if ({busy, ovf, done_cnt == 1, err_cnt == 0} !== 4'b0011)
      $display("FAIL ex_after: got busy=%0b ovf=%0b dones=%0d errs=%0d want 0 0 1 0", busy, ovf, done_cnt, err_cnt);
    else pas++;
  endtask

  task automatic test_wrap;
    int dc, want;
    for (int x = 0; x < 4; x++) begin
      ma[x] = 8'sd100;
      mb[x] = 8'sd1;
    end
`ifdef MATMUL_SAT_EN
    want = 127;
`else
    want = -56;
`endif
    model(2, 0);
    launch(2, 0);
    wait_done(dc);
    tot++; if (wr_errs(2) !== 0 || wd[0] !== want)
      $display("FAIL wrap_data: got %0d (%0d wrong) want %0d", wd.size() > 0 ? wd[0] : 999, wr_errs(2), want);
    else pas++;
    @(negedge clk);
    tot++; if (ovf !== 1'b1) $display("FAIL wrap_ovf: got %0b want 1", ovf); else pas++;
  endtask

  task automatic test_illegal;
    logic [2:0] bad[4] = '{3'd1, 3'd6, 3'd0, 3'd7};
    int dc;
    foreach (bad[s]) begin
      launch(bad[s], 0);
      wait_done(dc);
      @(negedge clk);
      tot++; if (dc !== 1 || done_cnt !== 1 || err_cnt !== 1)
        $display("FAIL illegal_done size=%0d: got cycle %0d dones %0d errs %0d want 1 1 1", bad[s], dc, done_cnt, err_cnt);
      else pas++;
      tot++; if (wa.size() !== 0 || act !== 0 || busy !== 1'b0 || ovf !== 1'b0)
        $display("FAIL illegal_quiet size=%0d: got writes %0d activity %0d busy %0b ovf %0b want 0", bad[s], wa.size(), act, busy, ovf);
      else pas++;
    end
  endtask

  task automatic test_forced_ovf;
    int dc;
    for (int x = 0; x < 9; x++) begin
      ma[x] = (x % 4 == 0) ? 8'sd1 : 8'sd0;
      mb[x] = 8'($urandom);
    end
    force_cyc = 2;
    model(3, 1);
    launch(3, 0);
    wait_done(dc);
    force_cyc = -1;
    tot++; if (dc !== lat(3) || wr_errs(3) !== 0)
      $display("FAIL forced_run: got cycle %0d, %0d wrong writes, want cycle %0d", dc, wr_errs(3), lat(3));
    else pas++;
    repeat (5) @(negedge clk);
    tot++; if (ovf !== 1'b1) $display("FAIL forced_sticky: got %0b want 1", ovf); else pas++;
    fill(2, 0);
    model(2, 0);
    launch(2, 0);
    wait_done(dc);
    @(negedge clk);
    tot++; if (ovf1 !== 0 || ovf !== 1'b0 || wr_errs(2) !== 0)
      $display("FAIL forced_clear: got ovf at start %0d, after %0b, %0d wrong want 0 0 0", ovf1, ovf, wr_errs(2));
    else pas++;
  endtask

  task automatic test_reset_mid;
    int dc, nw, bad = 0;
    fill(5, 1);
    model(5, 0);
    launch(5, 0);
    repeat (99) @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    tot++; if ({busy, done, err, c_wr_en, ovf, a_addr, b_addr, c_addr, mul_a, mul_b, c_data} !== '0)
      $display("FAIL midrst_outputs: got %h want 0", {busy, done, err, c_wr_en, ovf, a_addr, b_addr, c_addr, mul_a, mul_b, c_data});
    else pas++;
    nw = wa.size();
    rst = 0;
    for (int x = 0; x < nw; x++) if (wa[x] != x || wd[x] != ec[x]) bad++;
    repeat (30) @(negedge clk);
    tot++; if (nw == 0 || bad !== 0 || wa.size() !== nw || done_cnt !== 0 || busy !== 1'b0)
      $display("FAIL midrst_abort: got %0d writes (%0d wrong) then %0d, dones %0d, busy %0b", nw, bad, wa.size(), done_cnt, busy);
    else pas++;
    fill(2, 1);
    model(2, 0);
    launch(2, 0);
    wait_done(dc);
    @(negedge clk);
    tot++; if (dc !== 21 || wr_errs(2) !== 0 || ovf !== eovf)
      $display("FAIL midrst_rerun: got cycle %0d, %0d wrong, ovf %0b want 21 0 %0b", dc, wr_errs(2), ovf, eovf);
    else pas++;
  endtask

  task automatic test_random;
    int dc, n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(5, 2);
      fill(n, r[0]);
      model(n, 0);
      launch(3'(n), 0);
      wait_done(dc);
      @(negedge clk);
      tot++; if (dc !== lat(n) || wr_errs(n) !== 0 || busy_bad !== 0)
        $display("FAIL rand_run n=%0d: got cycle %0d, %0d wrong, %0d idle want %0d 0 0", n, dc, wr_errs(n), busy_bad, lat(n));
      else pas++;
      tot++; if (ovf !== eovf || busy !== 1'b0)
        $display("FAIL rand_ovf n=%0d: got ovf %0b busy %0b want %0b 0", n, ovf, busy, eovf);
      else pas++;
    end
  endtask

  task automatic test_busy_start;
    int dc;
    fill(4, 0);
    model(4, 0);
    spam = 1;
    spam_until = lat(4) - 2;
    launch(4, 0);
    wait_done(dc);
    spam = 0;
    repeat (4) @(negedge clk);
    tot++; if (dc !== lat(4) || wr_errs(4) !== 0 || done_cnt !== 1 || busy !== 1'b0)
      $display("FAIL busy_start: got cycle %0d, %0d wrong, dones %0d busy %0b want %0d 0 1 0", dc, wr_errs(4), done_cnt, busy, lat(4));
    else pas++;
  endtask

  task automatic test_back_to_back;
    int dc, dc2;
    logic b1, b2;
    fill(3, 1);
    model(3, 0);
    launch(3, 1);
    wait_done(dc);
    @(negedge clk);
    b1 = busy;
    @(negedge clk);
    b2 = busy;
    start = 0;
    tot++; if (dc !== lat(3) || wr_errs(3) !== 0 || {b1, b2} !== 2'b01)
      $display("FAIL b2b_first: got cycle %0d, %0d wrong, busy %0b%0b want %0d 0 01", dc, wr_errs(3), b1, b2, lat(3));
    else pas++;
    wa.delete();
    wd.delete();
    wait_done(dc2);
    tot++; if (dc2 !== lat(3) || wr_errs(3) !== 0)
      $display("FAIL b2b_second: got cycle %0d, %0d wrong want %0d 0", dc2, wr_errs(3), lat(3));
    else pas++;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_example;
    test_wrap;
    test_illegal;
    test_forced_ovf;
    test_reset_mid;
    test_random;
    test_busy_start;
    test_back_to_back;
    $display("%0d/%0d checks passed", pas, tot);
    $finish;
  end
endmodule
